// File: rtl/i2c_data_unit.sv
// Purpose : I2C datapath stage: bit-clock generator, MSB-first shift register,
//           ACK capture and open-drain SDA/SCL pad drive.
// Latency : SDA pad drive is registered (1 Clock); shift/sample act on ClockI2C edge strobes.
// Backpr. : none; the upstream controller sequences every bit via its control levels.
//
// Optional build macro: I2C_STRETCH_EN (slave clock stretching on SCL).
//
// Ports:
//   Clock, Reset              system clock, async active-high reset
//   BaudEnable                run the bit clock (0 = idle high, counter cleared)
//   ReadOrWrite               1 = release SDA (receive / ACK / stop)
//   Select                    SDA source: 1 = shift MSB, 0 = StartStopAck
//   ShiftOrHold               shift once on each ClockI2C falling edge
//   StartStopAck              SDA level for start/stop/ACK generation
//   WriteLoad, DataIn[7:0]    load byte to transmit (level)
//   SDAIn, SCLIn              asynchronous pad inputs
//   ClockI2C                  bit clock, idle high, fed back to the controller
//   SCLDriveLow, SDADriveLow  open-drain pull-down enables
//   ReadData[7:0]             shift-register contents
//   BitCount[3:0]             shifts since load, saturating at 8
//   ByteDone                  one-Clock pulse on the 8th shift
//   Nack                      last captured ACK bit (1 = NACK)
module i2c_data_unit #(
    parameter int BAUD_DIV = 250
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       BaudEnable,
    input  logic       ReadOrWrite,
    input  logic       Select,
    input  logic       ShiftOrHold,
    input  logic       StartStopAck,
    input  logic       WriteLoad,
    input  logic [7:0] DataIn,
    input  logic       SDAIn,
    input  logic       SCLIn,
    output logic       ClockI2C,
    output logic       SCLDriveLow,
    output logic       SDADriveLow,
    output logic [7:0] ReadData,
    output logic [3:0] BitCount,
    output logic       ByteDone,
    output logic       Nack
);

    localparam logic [11:0] BaudLast = 12'(BAUD_DIV - 1);

    logic [11:0] baudCount;
    logic        sdaMeta, sdaSync;
    logic        sclMeta, sclSync;
    logic        clockI2CDly;
    logic        sampledBit;
    logic        fallStrobe, riseStrobe;
    logic        stretchHold;
    logic        shiftNow;

    // Two-flop synchronisers for the asynchronous pad inputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sdaMeta <= 1'b1;
            sdaSync <= 1'b1;
            sclMeta <= 1'b1;
            sclSync <= 1'b1;
        end else begin
            sdaMeta <= SDAIn;
            sdaSync <= sdaMeta;
            sclMeta <= SCLIn;
            sclSync <= sclMeta;
        end
    end

`ifdef I2C_STRETCH_EN
    // A slave holding SCL low during our high phase freezes the count. Our own
    // release takes two synchroniser cycles to be seen, which adds 2 Clocks.
    assign stretchHold = ClockI2C & ~sclSync;
`else
    // SCL is still synchronised but never stalls the bit clock.
    assign stretchHold = 1'b0 & ClockI2C & ~sclSync;
`endif

    // Baud generator: toggles ClockI2C every BAUD_DIV Clocks while enabled.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            baudCount <= '0;
            ClockI2C  <= 1'b1;
        end else if (!BaudEnable) begin
            baudCount <= '0;
            ClockI2C  <= 1'b1;
        end else if (!stretchHold) begin
            if (baudCount == BaudLast) begin
                baudCount <= '0;
                ClockI2C  <= ~ClockI2C;
            end else begin
                baudCount <= baudCount + 12'd1;
            end
        end
    end

    // Edge strobes are valid for the single Clock after ClockI2C changes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clockI2CDly <= 1'b1;
        end else begin
            clockI2CDly <= ClockI2C;
        end
    end

    assign fallStrobe  = clockI2CDly & ~ClockI2C;
    assign riseStrobe  = ~clockI2CDly & ClockI2C;
    assign SCLDriveLow = ~ClockI2C;

    // A load in the same Clock as a fall wins; the shift is lost.
    assign shiftNow = ~WriteLoad & fallStrobe & ShiftOrHold;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ReadData <= '0;
            BitCount <= '0;
            ByteDone <= 1'b0;
        end else begin
            ByteDone <= shiftNow && (BitCount == 4'd7);
            if (WriteLoad) begin
                ReadData <= DataIn;
                BitCount <= '0;
            end else if (shiftNow) begin
                ReadData <= {ReadData[6:0], sampledBit};
                if (BitCount != 4'd8) begin
                    BitCount <= BitCount + 4'd1;
                end
            end
        end
    end

    // SDA is sampled while SCL is high; the ACK slot is the released, Select=0 phase.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sampledBit <= 1'b1;
            Nack       <= 1'b0;
        end else if (riseStrobe) begin
            sampledBit <= sdaSync;
            if (ReadOrWrite && !Select) begin
                Nack <= sdaSync;
            end
        end
    end

    // Registered SDA pad mux.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            SDADriveLow <= 1'b0;
        end else if (ReadOrWrite) begin
            SDADriveLow <= 1'b0;
        end else if (Select) begin
            SDADriveLow <= ~ReadData[7];
        end else begin
            SDADriveLow <= ~StartStopAck;
        end
    end

endmodule

// File: tb/tb_i2c_data_unit.sv
module tb_i2c_data_unit;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       BaudEnable, ReadOrWrite, Select, ShiftOrHold, StartStopAck, WriteLoad;
    logic [7:0] DataIn;
    logic       SDAIn, SCLIn;
    logic       ClockI2C, SCLDriveLow, SDADriveLow;
    logic [7:0] ReadData;
    logic [3:0] BitCount;
    logic       ByteDone, Nack;

    logic       slaveHold = 1'b0;
    // SCL pad is a wired-AND of our drive and a (possibly stretching) slave.
    assign SCLIn = ClockI2C & ~slaveHold;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [7:0] rd_m;
    logic       sampled_m;
    logic [7:0] drv_seq;

`ifdef I2C_STRETCH_EN
    localparam int HIGH_EXP    = 6;
    localparam int STRETCH_EXP = 16;
`else
    localparam int HIGH_EXP    = 4;
    localparam int STRETCH_EXP = 4;
`endif

    i2c_data_unit #(.BAUD_DIV(4)) dut (
        .Clock(Clock), .Reset(Reset), .BaudEnable(BaudEnable), .ReadOrWrite(ReadOrWrite),
        .Select(Select), .ShiftOrHold(ShiftOrHold), .StartStopAck(StartStopAck),
        .WriteLoad(WriteLoad), .DataIn(DataIn), .SDAIn(SDAIn), .SCLIn(SCLIn),
        .ClockI2C(ClockI2C), .SCLDriveLow(SCLDriveLow), .SDADriveLow(SDADriveLow),
        .ReadData(ReadData), .BitCount(BitCount), .ByteDone(ByteDone), .Nack(Nack)
    );

    always #5 Clock = ~Clock;

    // Wait until ClockI2C is seen changing to 'lvl'; returns #1 after that edge.
    task automatic wait_edge(input logic lvl);
        logic prev;
        int   n;
        bit   done;
        prev = ClockI2C;
        n    = 0;
        done = 0;
        while (!done) begin
            @(posedge Clock); #1;
            n++;
            if (prev !== lvl && ClockI2C === lvl) begin
                done = 1;
            end else if (n > 200) begin
                tests++; fails++;
                $display("FAIL wait_edge timeout: ClockI2C=%0b never reached %0b", ClockI2C, lvl);
                done = 1;
            end
            prev = ClockI2C;
        end
        if (lvl) sampled_m = SDAIn;
    endtask

    task automatic load_byte(input logic [7:0] b);
        DataIn = b; WriteLoad = 1'b1;
        @(posedge Clock); #1;
        WriteLoad = 1'b0;
        rd_m = b;
    endtask

    // Transmit one byte, checking the pad level before every fall and every shift result.
    task automatic run_byte(input logic [7:0] b, input bit rnd_sda, input bit keep_shift);
        wait_edge(1'b0);
        SDAIn = rnd_sda ? 1'($urandom_range(0, 1)) : 1'b1;
        wait_edge(1'b1);
        load_byte(b);
        tests++;
        if (ReadData !== b || BitCount !== 4'd0) begin
            fails++;
            $display("FAIL load: ReadData=%h BitCount=%0d want %h 0", ReadData, BitCount, b);
        end
        Select = 1'b1; ReadOrWrite = 1'b0; ShiftOrHold = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                @(posedge Clock); #1;
            end else begin
                wait_edge(1'b1);
            end
            drv_seq[7-k] = SDADriveLow;
            tests++;
            if (SDADriveLow !== ~rd_m[7] || BitCount !== 4'(k)) begin
                fails++;
                $display("FAIL bit%0d drive: SDADriveLow=%0b BitCount=%0d want %0b %0d",
                         k, SDADriveLow, BitCount, ~rd_m[7], k);
            end
            wait_edge(1'b0);
            SDAIn = rnd_sda ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge Clock); #1;
            rd_m = {rd_m[6:0], sampled_m};
            tests++;
            if (ReadData !== rd_m || BitCount !== 4'(k + 1) || ByteDone !== (k == 7)) begin
                fails++;
                $display("FAIL shift%0d: ReadData=%h BitCount=%0d ByteDone=%0b want %h %0d %0b",
                         k, ReadData, BitCount, ByteDone, rd_m, k + 1, (k == 7));
            end
        end
        @(posedge Clock); #1;
        tests++;
        if (ByteDone !== 1'b0) begin
            fails++;
            $display("FAIL bytedone_pulse: ByteDone=%0b want 0", ByteDone);
        end
        if (!keep_shift) ShiftOrHold = 1'b0;
    endtask

    task automatic test_reset();
        bit bad;
        Reset = 1'b1; BaudEnable = 1'b0; ReadOrWrite = 1'b1; Select = 1'b0;
        ShiftOrHold = 1'b0; StartStopAck = 1'b1; WriteLoad = 1'b0; DataIn = 8'h00; SDAIn = 1'b1;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge Clock); #1;
            bad = (ClockI2C !== 1'b1) || (SDADriveLow !== 1'b0) || (ReadData !== 8'h00) ||
                  (Nack !== 1'b0) || (BitCount !== 4'd0) || (SCLDriveLow !== 1'b0) || (ByteDone !== 1'b0);
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL reset_idle cyc%0d: ClockI2C=%0b SDADriveLow=%0b ReadData=%h Nack=%0b BitCount=%0d",
                         i, ClockI2C, SDADriveLow, ReadData, Nack, BitCount);
            end
        end
    endtask

    task automatic count_until(input logic lvl, output int n);
        n = 0;
        do begin
            @(posedge Clock); #1;
            n++;
        end while (ClockI2C !== lvl && n < 100);
    endtask

    task automatic test_baud_timing();
        int n;
        BaudEnable = 1'b1;
        count_until(1'b0, n);
        tests++;
        if (n != 4) begin fails++; $display("FAIL first_fall: %0d cycles want 4", n); end
        count_until(1'b1, n);
        tests++;
        if (n != 4) begin fails++; $display("FAIL low_phase: %0d cycles want 4", n); end
        count_until(1'b0, n);
        tests++;
        if (n != HIGH_EXP) begin fails++; $display("FAIL high_phase: %0d cycles want %0d", n, HIGH_EXP); end
        BaudEnable = 1'b0;
        @(posedge Clock); #1;
        tests++;
        if (ClockI2C !== 1'b1 || SCLDriveLow !== 1'b0) begin
            fails++;
            $display("FAIL baud_off: ClockI2C=%0b SCLDriveLow=%0b want 1 0", ClockI2C, SCLDriveLow);
        end
    endtask

    task automatic test_serialise_a5();
        BaudEnable = 1'b1;
        run_byte(8'hA5, 0, 1);
        tests++;
        if (drv_seq !== 8'b0101_1010 || ReadData !== 8'hFF || BitCount !== 4'd8) begin
            fails++;
            $display("FAIL a5_seq: drive=%b ReadData=%h BitCount=%0d want 01011010 ff 8",
                     drv_seq, ReadData, BitCount);
        end
        // One more shift with ShiftOrHold still high: count saturates.
        wait_edge(1'b1);
        wait_edge(1'b0);
        @(posedge Clock); #1;
        tests++;
        if (BitCount !== 4'd8 || ByteDone !== 1'b0 || ReadData !== 8'hFF) begin
            fails++;
            $display("FAIL saturate: BitCount=%0d ByteDone=%0b ReadData=%h want 8 0 ff",
                     BitCount, ByteDone, ReadData);
        end
        ShiftOrHold = 1'b0;
    endtask

    task automatic test_random_bytes();
        for (int i = 0; i < 4; i++) run_byte(8'($urandom), 1, 0);
    endtask

    task automatic test_load_collision();
        logic [7:0] b;
        b = 8'($urandom);
        ShiftOrHold = 1'b1;
        wait_edge(1'b0);
        DataIn = b; WriteLoad = 1'b1;
        @(posedge Clock); #1;
        WriteLoad = 1'b0;
        tests++;
        if (ReadData !== b || BitCount !== 4'd0) begin
            fails++;
            $display("FAIL load_vs_fall: ReadData=%h BitCount=%0d want %h 0", ReadData, BitCount, b);
        end
        ShiftOrHold = 1'b0;
    endtask

    task automatic test_ack_capture();
        logic [5:0] pat;
        logic       keep;
        pat = {3'($urandom), 3'b101};
        ReadOrWrite = 1'b1; Select = 1'b0; ShiftOrHold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_edge(1'b0);
            SDAIn = pat[i];
            wait_edge(1'b1);
            @(posedge Clock); #1;
            tests++;
            if (Nack !== pat[i] || SDADriveLow !== 1'b0) begin
                fails++;
                $display("FAIL ack%0d: Nack=%0b SDADriveLow=%0b want %0b 0", i, Nack, SDADriveLow, pat[i]);
            end
        end
        // Outside the ACK slot Nack must hold.
        keep = pat[5];
        ReadOrWrite = 1'b0; StartStopAck = 1'b1;
        wait_edge(1'b0);
        SDAIn = ~keep;
        wait_edge(1'b1);
        @(posedge Clock); #1;
        tests++;
        if (Nack !== keep) begin fails++; $display("FAIL ack_hold: Nack=%0b want %0b", Nack, keep); end
        ReadOrWrite = 1'b1;
    endtask

    task automatic test_sda_mux();
        logic exp;
        BaudEnable = 1'b0;
        @(posedge Clock); #1;
        load_byte(8'($urandom));
        for (int i = 0; i < 8; i++) begin
            ReadOrWrite  = 1'($urandom_range(0, 1));
            Select       = 1'($urandom_range(0, 1));
            StartStopAck = 1'($urandom_range(0, 1));
            exp = ReadOrWrite ? 1'b0 : (Select ? ~rd_m[7] : ~StartStopAck);
            @(posedge Clock); #1;
            tests++;
            if (SDADriveLow !== exp) begin
                fails++;
                $display("FAIL mux%0d: SDADriveLow=%0b want %0b (rw=%0b sel=%0b ssa=%0b)",
                         i, SDADriveLow, exp, ReadOrWrite, Select, StartStopAck);
            end
        end
        ReadOrWrite = 1'b1;
    endtask

    task automatic test_baud_disable();
        BaudEnable = 1'b1;
        wait_edge(1'b0);
        SDAIn = 1'($urandom_range(0, 1));
        wait_edge(1'b1);
        load_byte(8'($urandom));
        ShiftOrHold = 1'b1;
        wait_edge(1'b0);
        @(posedge Clock); #1;
        rd_m = {rd_m[6:0], sampled_m};
        BaudEnable = 1'b0;
        @(posedge Clock); #1;
        tests++;
        if (ClockI2C !== 1'b1) begin fails++; $display("FAIL disable_clk: ClockI2C=%0b want 1", ClockI2C); end
        repeat (6) @(posedge Clock);
        #1;
        tests++;
        if (ReadData !== rd_m || BitCount !== 4'd1) begin
            fails++;
            $display("FAIL disable_hold: ReadData=%h BitCount=%0d want %h 1", ReadData, BitCount, rd_m);
        end
        ShiftOrHold = 1'b0;
    endtask

    task automatic test_stretch();
        int fell;
        BaudEnable = 1'b1;
        wait_edge(1'b0);
        wait_edge(1'b1);
        fell = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge Clock); #1;
            if (i == 1)  slaveHold = 1'b1;
            if (i == 11) slaveHold = 1'b0;
            if (fell == 0 && ClockI2C === 1'b0) fell = i;
            if (i >= 11 && fell != 0) break;
        end
        slaveHold = 1'b0;
        tests++;
        if (fell != STRETCH_EXP) begin
            fails++;
            $display("FAIL stretch_high: %0d cycles want %0d", fell, STRETCH_EXP);
        end
    endtask

    task automatic test_async_reset();
        BaudEnable = 1'b1;
        ReadOrWrite = 1'b0; Select = 1'b1;
        wait_edge(1'b0);
        wait_edge(1'b1);
        load_byte(8'h3C);
        ShiftOrHold = 1'b1;
        repeat (3) begin
            wait_edge(1'b0);
            @(posedge Clock); #1;
        end
        ShiftOrHold = 1'b0; Select = 1'b0; StartStopAck = 1'b0;
        @(posedge Clock); #1;
        tests++;
        if (BitCount !== 4'd3 || SDADriveLow !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: BitCount=%0d SDADriveLow=%0b want 3 1", BitCount, SDADriveLow);
        end
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        tests++;
        if (ReadData !== 8'h00 || BitCount !== 4'd0 || SDADriveLow !== 1'b0 || ClockI2C !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: ReadData=%h BitCount=%0d SDADriveLow=%0b ClockI2C=%0b want 00 0 0 1",
                     ReadData, BitCount, SDADriveLow, ClockI2C);
        end
        ReadOrWrite = 1'b1; BaudEnable = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        tests++;
        if (SDADriveLow !== 1'b0 || SCLDriveLow !== 1'b0) begin
            fails++;
            $display("FAIL release_pads: SDADriveLow=%0b SCLDriveLow=%0b want 0 0", SDADriveLow, SCLDriveLow);
        end
    endtask

    initial begin
        sampled_m = 1'b1;
        rd_m      = 8'h00;
        drv_seq   = 8'h00;
        test_reset();
        test_baud_timing();
        test_serialise_a5();
        test_random_bytes();
        test_load_collision();
        test_ack_capture();
        test_sda_mux();
        test_baud_disable();
        test_stretch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_data_unit.md
Name: i2c_data_unit

Overview:
Datapath stage directly downstream of the I2C phase-1 controller; consumes BaudEnable, ReadOrWrite, Select, ShiftOrHold, StartStopAck and WriteLoad.
Generates the I2C bit clock (ClockI2C, fed back to the controller), serialises a loaded byte MSB-first onto SDA, captures returned bits and the slave ACK, and drives the open-drain SDA/SCL pads.

Parameters:
BAUD_DIV, 250, system clocks per ClockI2C half-period (50 MHz / (2*250) = 100 kHz); legal range 2..4095; 12-bit counter.

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high; clock Clock
BaudEnable  in  1  1 = run bit clock; 0 = hold counter 0 and ClockI2C high
ReadOrWrite  in  1  1 = release SDA (receive/ACK/stop phase)
Select  in  1  1 = SDA source is shift-register MSB; 0 = StartStopAck
ShiftOrHold  in  1  1 = shift on the next ClockI2C falling edge
StartStopAck  in  1  SDA level when Select=0 and ReadOrWrite=0
WriteLoad  in  1  load DataIn into shift register (level)
DataIn  in  8  byte to transmit
SDAIn  in  1  SDA pad input (asynchronous)
SCLIn  in  1  SCL pad input (asynchronous); used only with stretching
ClockI2C  out  1  internal bit clock, idle high
SCLDriveLow  out  1  1 = pull SCL low; equals ~ClockI2C
SDADriveLow  out  1  1 = pull SDA low; 0 = release
ReadData  out  8  current shift-register contents
BitCount  out  4  shifts since last load, 0..8, saturates at 8
ByteDone  out  1  one-Clock pulse on 8th shift
Nack  out  1  last sampled ACK bit (1 = NACK)

Behaviour:
- Reset values: ClockI2C=1, SCLDriveLow=0, SDADriveLow=0, ReadData=0, BitCount=0, ByteDone=0, Nack=0, baud counter=0, SDA/SCL synchronisers=1, SampledBit=1.
- Synchronisers: SDAIn and SCLIn each pass through 2 flops before any use.
- Baud generator:
  - BaudEnable=0: counter forced 0, ClockI2C forced 1 on the next edge.
  - BaudEnable=1: counter increments each Clock. At BAUD_DIV-1, counter goes to 0 and ClockI2C toggles.
  - The first fall occurs BAUD_DIV clocks after BaudEnable is first sampled high. Full period is 2*BAUD_DIV clocks.
- Edge strobes: fall = the cycle in which the registered ClockI2C goes 1->0; rise = the cycle in which it goes 0->1. Each strobe lasts exactly one Clock.
- On rise: SampledBit <= synchronised SDA.
- Shift register, priority order:
  - WriteLoad=1: ReadData <= DataIn, BitCount <= 0.
  - Else fall AND ShiftOrHold=1: ReadData <= {ReadData[6:0], SampledBit}, and BitCount increments (saturates at 8).
  - Otherwise hold.
  - A level-held ShiftOrHold shifts once per fall, never once per Clock.
- ByteDone=1 for exactly the one Clock in which BitCount goes from 7 to 8.
- SDA mux, registered with 1 Clock latency:
  - ReadOrWrite=1 -> SDADriveLow=0.
  - Else Select=1 -> SDADriveLow = ~ReadData[7].
  - Else -> SDADriveLow = ~StartStopAck.
- ACK capture: on rise with ReadOrWrite=1 and Select=0, Nack <= synchronised SDA. Otherwise Nack holds.
- Simultaneous WriteLoad and fall: the load wins and the shift is dropped.
- BaudEnable deasserted mid-bit: the counter clears and ClockI2C returns high. Shift register and BitCount hold.
- Reset asserted mid-byte: all state goes immediately (asynchronously) to reset values. On release, both pads are released.

Optional Feature:
I2C_STRETCH_EN
- Defined: clock stretching is supported. While ClockI2C=1 and synchronised SCLIn=0, the baud counter freezes; counting resumes once SCLIn is seen high. The high phase is extended by the stretch time plus 2 synchroniser cycles.
- Undefined: SCLIn is ignored, and timing is exactly 2*BAUD_DIV per bit.

Test Plan:
1. All benches use BAUD_DIV=4. Pulse Reset with BaudEnable=0 -> ClockI2C=1, SDADriveLow=0, ReadData=8'h00, Nack=0. These values hold for 50 cycles.
2. Raise BaudEnable at cycle T -> ClockI2C falls at T+4 and rises at T+8, giving an 8-cycle period. Drop BaudEnable -> ClockI2C is 1 on the next edge.
3. WriteLoad with DataIn=8'hA5, then Select=1, ShiftOrHold=1, ReadOrWrite=0, SDAIn=1:
   - SDADriveLow read at each rise is 0,1,0,1,1,0,1,0.
   - ByteDone pulses once, BitCount=8, ReadData=8'hFF.
4. ReadOrWrite=1, Select=0, SDAIn=0 across a rise -> Nack=0 and SDADriveLow=0. Repeat with SDAIn=1 -> Nack=1.
5. Assert Reset after 3 shifts of 8'h3C -> ReadData, BitCount and SDADriveLow are 0 within the same cycle, with no Clock edge needed.
6. With I2C_STRETCH_EN defined, hold SCLIn low for 10 cycles starting 1 cycle after a rise -> that high phase lasts 4+10+2 cycles.
   - Without the macro, the same stimulus leaves the high phase at 4 cycles.
